fraise_posterior_accumulator: RTL
=================================

// Module: fraise_posterior_accumulator
// PURPOSE
//  Downstream stage of the stochastic Bayesian array controller: consumes the per-cycle bit_out
//  vector (one stochastic bit per matrix line) during an inference window, counts ones per line,
//  selects the argmax line (posterior winner) and streams the counts plus winner word to the
//  response/writeback path over a valid/ready handshake. Decouples array timing from bus back-pressure.
// PARAMETERS
//  MatrixSize   4    number of matrix lines = width of bit_out_i, number of counters
//  CountWidth   8    width of each per-line ones counter (saturating)
//  NbrSamples   255  accepted samples per inference window (1..2**CountWidth-1)
//  DataWidth    32   width of result_data_o
// PORTS
//  clk_i            in   1                  clock, all logic on rising edge
//  reset_i          in   1                  synchronous, active-high reset
//  start_i          in   1                  pulse: open a new inference window (honoured only in IDLE)
//  sample_valid_i   in   1                  bit_out_i holds a valid sample this cycle
//  bit_out_i        in   MatrixSize         stochastic output bits from the array, bit i = line i
//  busy_o           out  1                  high in every state except IDLE
//  result_valid_o   out  1                  result_data_o valid; held until accepted
//  result_ready_i   in   1                  consumer accepts word when valid&ready
//  result_data_o    out  DataWidth          result word (format below)
//  result_last_o    out  1                  marks the final (winner) word of a drain
// BEHAVIOUR
//  Reset: state=IDLE, all counters/sample_cnt/winner=0, busy_o=0, result_valid_o=0,
//   result_data_o=0, result_last_o=0. Reset mid-operation aborts: nothing further emitted.
//  IDLE: start_i -> clear all counters and sample_cnt next cycle, go ACCUM. sample_valid_i ignored
//   in IDLE (incl. same cycle as start_i).
//  ACCUM: on sample_valid_i: count[i] += bit_out_i[i], saturating at 2**CountWidth-1; sample_cnt++.
//   Sample with sample_cnt==NbrSamples-1 is the last one counted -> go ARGMAX. Gaps in
//   sample_valid_i allowed, no timeout. start_i ignored outside IDLE.
//  ARGMAX: one compare per cycle, index j=0..MatrixSize-1, exactly MatrixSize cycles; winner
//   updated only on strictly greater count -> ties resolve to lowest index. Then DRAIN, k=0.
//  DRAIN: emits MatrixSize+1 words in order. Word k<MatrixSize: [31:16]=k, [CountWidth-1:0]=count[k],
//   other bits 0. Final word: [31]=1, [CountWidth+15:16]=count[winner], [15:0]=winner index,
//   result_last_o=1. Words are registered; valid rises first DRAIN cycle; data/last stable while
//   valid&!ready; next word presented cycle after handshake (one word/cycle at full throughput).
//   After final handshake -> IDLE, busy_o=0 same cycle as IDLE entry.
//  Latency: last sample accepted at cycle t -> first result_valid_o at t+MatrixSize+1.
//  Widths: counters never wrap; DataWidth>=CountWidth+16 required (elaboration assertion).
// STRUCTURE
//  fraise_pkg: acc_state_e {IDLE, ACCUM, ARGMAX, DRAIN}, RESULT_LAST_BIT=31, RESULT_IDX_LSB=16.
//  Sub-module fraise_sat_counter (clear, inc, saturating, CountWidth) instantiated MatrixSize times.
//  FSM, sample counter, argmax pointer and drain pointer in top.
// TESTING
//  1 reset, start, 255 samples bit_out_i=4'b0101 -> counts {255,0,255,0}, winner word idx 0 (tie low).
//  2 bit_out_i=4'b1000 for 10 samples then 4'b0100 for 245 -> counts {0,0,245,10}, winner 2,
//    first valid exactly MatrixSize+1 cycles after last sample.
//  3 result_ready_i low 5 cycles per word during drain -> data/last stable, 5 words total, last on word 5.
//  4 sample_valid_i toggling 50%, start_i pulsed during ACCUM and drain -> ignored, counts exact.
//  5 NbrSamples=300, CountWidth=8 (override), all-ones input -> counts saturate at 255, no wrap.
//  6 reset_i asserted mid-ACCUM and mid-DRAIN -> next cycle IDLE, valid=0, busy=0, new start works.

Source files
------------

// File: rtl/fraise_posterior_accumulator_pkg.sv
// Shared types and result-word layout for the posterior accumulator.
package fraise_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      ARGMAX,
      DRAIN
   } acc_state_e;

   localparam int RESULT_LAST_BIT = 31;
   localparam int RESULT_IDX_LSB  = 16;

endpackage

// File: rtl/fraise_posterior_accumulator_if.sv
// Sample-in / result-out signal bundle; master is the environment, slave is the accumulator.
interface fraise_posterior_accumulator_if #(
   parameter int MatrixSize = 4,
   parameter int DataWidth  = 32
) ();

   logic                  start;
   logic                  sample_valid;
   logic [MatrixSize-1:0] bit_out;
   logic                  busy;
   logic                  result_valid;
   logic                  result_ready;
   logic [DataWidth-1:0]  result_data;
   logic                  result_last;

   modport master (
      output start, sample_valid, bit_out, result_ready,
      input  busy, result_valid, result_data, result_last
   );

   modport slave (
      input  start, sample_valid, bit_out, result_ready,
      output busy, result_valid, result_data, result_last
   );

endinterface

// File: rtl/fraise_sat_counter.sv
// Per-line ones counter: synchronous clear, increments stick at the all-ones value.
module fraise_sat_counter #(
   parameter int CountWidth = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  clear_i,
   input  logic                  inc_i,
   output logic [CountWidth-1:0] count_o
);

   localparam logic [CountWidth-1:0] CountMax = '1;

   logic [CountWidth-1:0] count_q;
   logic [CountWidth-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != CountMax)) begin
         count_d = count_q + CountWidth'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fraise_posterior_accumulator.sv
// Counts stochastic ones per matrix line over an inference window, picks the argmax line and
// streams the counts plus a winner word out over a valid/ready handshake.
module fraise_posterior_accumulator
   import fraise_pkg::*;
#(
   parameter int MatrixSize = 4,
   parameter int CountWidth = 8,
   parameter int NbrSamples = 255,
   parameter int DataWidth  = 32
) (
   input logic                           clk_i,
   input logic                           reset_i,
   fraise_posterior_accumulator_if.slave acc_bus
);

   localparam int IdxWidth = (MatrixSize > 1) ? $clog2(MatrixSize) : 1;
   localparam int SmpWidth = $clog2(NbrSamples + 1);
   localparam logic [SmpWidth-1:0] LastSample = SmpWidth'(NbrSamples - 1);
   localparam logic [IdxWidth-1:0] LastLine   = IdxWidth'(MatrixSize - 1);

   if ((DataWidth < CountWidth + RESULT_IDX_LSB) || (DataWidth <= RESULT_LAST_BIT)) begin : g_width_check
      $error("fraise_posterior_accumulator: DataWidth too narrow for the result word");
   end

   acc_state_e             state_q, state_d;
   logic [SmpWidth-1:0]    sample_cnt_q, sample_cnt_d;
   logic [IdxWidth-1:0]    arg_idx_q, arg_idx_d;
   logic [IdxWidth-1:0]    drain_idx_q, drain_idx_d;
   logic [IdxWidth-1:0]    winner_q, winner_d;
   logic                   busy_q, busy_d;
   logic                   valid_q, valid_d;
   logic [DataWidth-1:0]   data_q, data_d;
   logic                   last_q, last_d;

   logic [CountWidth-1:0]  count [MatrixSize];
   logic                   counters_clear;
   logic                   sample_accept;
   logic [IdxWidth-1:0]    drain_next;

   assign sample_accept = (state_q == ACCUM) && acc_bus.sample_valid;
   assign drain_next    = drain_idx_q + IdxWidth'(1);

   for (genvar gi = 0; gi < MatrixSize; gi++) begin : g_line
      fraise_sat_counter #(
         .CountWidth(CountWidth)
      ) u_counter (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .clear_i (counters_clear),
         .inc_i   (sample_accept && acc_bus.bit_out[gi]),
         .count_o (count[gi])
      );
   end

   function automatic logic [DataWidth-1:0] line_word(input logic [IdxWidth-1:0]   idx,
                                                      input logic [CountWidth-1:0] cnt);
      logic [DataWidth-1:0] w;
      w = '0;
      w[RESULT_IDX_LSB +: 16] = 16'(idx);
      w[CountWidth-1:0]       = cnt;
      return w;
   endfunction

   function automatic logic [DataWidth-1:0] winner_word(input logic [IdxWidth-1:0]   idx,
                                                        input logic [CountWidth-1:0] cnt);
      logic [DataWidth-1:0] w;
      w = '0;
      w[RESULT_LAST_BIT]              = 1'b1;
      w[RESULT_IDX_LSB +: CountWidth] = cnt;
      w[15:0]                         = 16'(idx);
      return w;
   endfunction

   always_comb begin
      state_d        = state_q;
      sample_cnt_d   = sample_cnt_q;
      arg_idx_d      = arg_idx_q;
      drain_idx_d    = drain_idx_q;
      winner_d       = winner_q;
      busy_d         = busy_q;
      valid_d        = valid_q;
      data_d         = data_q;
      last_d         = last_q;
      counters_clear = 1'b0;

      case (state_q)
         IDLE: begin
            if (acc_bus.start) begin
               counters_clear = 1'b1;
               sample_cnt_d   = '0;
               busy_d         = 1'b1;
               state_d        = ACCUM;
            end
         end
         ACCUM: begin
            if (acc_bus.sample_valid) begin
               sample_cnt_d = sample_cnt_q + SmpWidth'(1);
               if (sample_cnt_q == LastSample) begin
                  arg_idx_d = '0;
                  winner_d  = '0;
                  state_d   = ARGMAX;
               end
            end
         end
         ARGMAX: begin
            // Strictly-greater update keeps the lowest index on ties.
            if (count[arg_idx_q] > count[winner_q]) begin
               winner_d = arg_idx_q;
            end
            if (arg_idx_q == LastLine) begin
               drain_idx_d = '0;
               valid_d     = 1'b1;
               last_d      = 1'b0;
               data_d      = line_word('0, count[0]);
               state_d     = DRAIN;
            end else begin
               arg_idx_d = arg_idx_q + IdxWidth'(1);
            end
         end
         DRAIN: begin
            if (valid_q && acc_bus.result_ready) begin
               if (last_q) begin
                  busy_d  = 1'b0;
                  valid_d = 1'b0;
                  data_d  = '0;
                  last_d  = 1'b0;
                  state_d = IDLE;
               end else if (drain_idx_q == LastLine) begin
                  data_d = winner_word(winner_q, count[winner_q]);
                  last_d = 1'b1;
               end else begin
                  drain_idx_d = drain_next;
                  data_d      = line_word(drain_next, count[drain_next]);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         sample_cnt_q <= '0;
         arg_idx_q    <= '0;
         drain_idx_q  <= '0;
         winner_q     <= '0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         arg_idx_q    <= arg_idx_d;
         drain_idx_q  <= drain_idx_d;
         winner_q     <= winner_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         last_q       <= last_d;
      end
   end

   assign acc_bus.busy         = busy_q;
   assign acc_bus.result_valid = valid_q;
   assign acc_bus.result_data  = data_q;
   assign acc_bus.result_last  = last_q;

endmodule
